uart_transmitter: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/parity_gen.sv | 19 +
 rtl/uart_bit_timer.sv | 49 ++++
 rtl/uart_transmitter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path: frame-state enum,
//   data/frame widths, the idle line level and the bit-timer width.
package uart_pkg;

   localparam int   DATA_W     = 8;
   localparam int   FRAME_BITS = 11;     // start + 8 data + parity + stop
   localparam logic LINE_IDLE  = 1'b1;
   localparam int   TIMER_W    = 16;     // holds CLKS_PER_BIT-1 up to 65534

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

endpackage

// File: rtl/parity_gen.sv
// parity_gen
//   Parity of a data word. Shared by the UART transmitter and receiver so
//   both ends always agree on polarity.
//   Parameters: WIDTH (data width), ODD (0 = even, nonzero = odd parity).
//   Ports:
//     data_i   [WIDTH-1:0]  word to protect
//     parity_o              parity bit to send alongside data_i
module parity_gen #(
   parameter int WIDTH = 8,
   parameter int ODD   = 0
) (
   input  logic [WIDTH-1:0] data_i,
   output logic             parity_o
);

   // Even parity is the plain XOR reduction; odd parity inverts it.
   assign parity_o = (^data_i) ^ (ODD != 0);

endmodule

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 while running, wrapping to 0
//   at each bit boundary; bit_tick_o marks the last clock of every bit.
//   Parameters: CLKS_PER_BIT (1..65535).
//   Ports:
//     clk_i       system clock
//     rst_i       synchronous active-high reset
//     restart_i   start a fresh bit period (a frame is being accepted)
//     run_i       a frame is in flight; the counter holds at 0 otherwise
//     bit_tick_o  final clock of the current bit period
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   input  logic run_i,
   output logic bit_tick_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLKS_PER_BIT - 1);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (restart_i || !run_i) begin
         count_d = '0;
      end else if (count_q == LAST) begin
         count_d = '0;
      end else begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // With CLKS_PER_BIT = 1, LAST is 0 and every running clock is a tick.
   assign bit_tick_o = run_i && !restart_i && (count_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises bytes into UART frames: start (0), 8 data bits LSB first,
//   parity, stop (1). Each bit is held CLKS_PER_BIT clocks, so a frame is
//   11*CLKS_PER_BIT clocks long.
//   Handshake: a byte is taken on a rising edge where tx_valid && tx_ready
//   are both high; until then the host holds tx_valid and keeps tx_data
//   stable. tx_ready is low whenever rst is high.
//   Build option UART_TX_SKID_EN: adds a one-entry holding register so a
//   byte can be accepted while a frame is in flight and the next frame
//   starts on the clock right after the stop bit. Without it a byte is only
//   accepted in IDLE, leaving one idle-high clock between frames.
//   Parameters: CLKS_PER_BIT (1..65535), PARITY_ODD (0 even, 1 odd).
//   Ports:
//     clk          system clock
//     rst          synchronous active-high reset; aborts any frame
//     tx_data[7:0] byte to send, latched on the accepting edge
//     tx_valid     host offers tx_data
//     tx_ready     a byte can be accepted this cycle
//     TX_OUT       serial line, idle high
//     tx_busy      frame in progress (START..STOP)
//     tx_done      one-clock pulse on the last clock of the stop bit
//     dbg_state_o  current frame state
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              TX_OUT,
   output logic              tx_busy,
   output logic              tx_done,
   output uart_state_e       dbg_state_o
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              parity_q, parity_d;
   logic              tx_out_q, tx_out_d;

   logic              accept;
   logic              bit_tick;
   logic [DATA_W-1:0] load_byte;
   logic              load_parity;

`ifdef UART_TX_SKID_EN
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;

   assign tx_ready  = !hold_valid_q && !rst;
   // A parked byte always goes out before anything on tx_data.
   assign load_byte = hold_valid_q ? hold_q : tx_data;
`else
   assign tx_ready  = (state_q == IDLE) && !rst;
   assign load_byte = tx_data;
`endif

   assign accept = tx_valid && tx_ready;

   parity_gen #(
      .WIDTH (DATA_W),
      .ODD   (PARITY_ODD)
   ) u_parity (
      .data_i   (load_byte),
      .parity_o (load_parity)
   );

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .restart_i  ((state_q == IDLE) && accept),
      .run_i      (state_q != IDLE),
      .bit_tick_o (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
`ifdef UART_TX_SKID_EN
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (accept && (state_q != IDLE)) begin
         hold_d       = tx_data;
         hold_valid_d = 1'b1;
      end
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               shift_d   = load_byte;
               parity_d  = load_parity;
               bit_cnt_d = '0;
            end
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = PARITY;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) state_d = STOP;
         end
         STOP: begin
            if (bit_tick) begin
`ifdef UART_TX_SKID_EN
               // Chain straight into the next frame. A byte offered on this
               // very edge with the holder empty is loaded directly rather
               // than parked, so it is never stranded in IDLE.
               if (hold_valid_q || accept) begin
                  state_d      = START;
                  shift_d      = load_byte;
                  parity_d     = load_parity;
                  bit_cnt_d    = '0;
                  hold_valid_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered from the next state so TX_OUT is glitch-free.
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
         PARITY:  tx_out_d = parity_d;
         default: tx_out_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_out_q  <= LINE_IDLE;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tx_out_q  <= tx_out_d;
      end
   end

`ifdef UART_TX_SKID_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end
`endif

   assign TX_OUT      = tx_out_q;
   assign tx_busy     = (state_q != IDLE);
   assign tx_done     = (state_q == STOP) && bit_tick;
   assign dbg_state_o = state_q;

endmodule
